// File: rtl/deserializer.sv
// Serial-to-parallel receiver with a one-entry holding register.
// Flags short/long frames and overruns of the holding register.
module deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_input,
  input  logic             frame,
  output logic [WIDTH-1:0] par_output,
  output logic             full,
  input  logic             ack,
  output logic             frame_error,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pos;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_w;
  logic [WIDTH-1:0] par_q, par_d;
  logic full_q, full_d;
  logic fe_q, fe_d;
  logic ovr_q, ovr_d;
  logic xtra_q, xtra_d;
  logic done;

  // Place the incoming bit into the partial word at its ordered slot
  always_comb begin
    pos = LSB_FIRST ? cnt_q : (CW'(WIDTH - 1) - cnt_q);
    word_w = shift_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == pos) word_w[i] = ser_input;
    end
  end

  // Frame tracking: next state, bit count and error pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    xtra_d  = xtra_q;
    fe_d    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame) begin
          shift_d = word_w;
          cnt_d   = CW'(1);
          xtra_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (frame) begin
          shift_d = word_w;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            done    = 1'b1;
            state_d = FLUSH;
          end
        end else begin
          fe_d    = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (frame) begin
          if (!xtra_q) begin
            fe_d   = 1'b1;
            xtra_d = 1'b1;
          end
        end else begin
          shift_d = '0;
          cnt_d   = '0;
          xtra_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load, read-out and overrun bookkeeping
  always_comb begin
    par_d  = par_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    if (done && (!full_q || ack)) begin
      par_d  = word_w;
      full_d = 1'b1;
    end else if (ack && full_q) begin
      full_d = 1'b0;
    end
    if (done && full_q && !ack) begin
      ovr_d = 1'b1;
    end else if (ack && full_q) begin
      ovr_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= '0;
      full_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      xtra_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      full_q  <= full_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      xtra_q  <= xtra_d;
    end
  end

  assign par_output  = par_q;
  assign full        = full_q;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: both bit orders driven in lockstep,
// checked against a frame-length reference model and fixed vectors.
module tb_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ser_input = 1'b0;
  logic frame = 1'b0;
  logic ack = 1'b0;

  logic [W-1:0] par_l, par_m;
  logic full_l, full_m, fe_l, fe_m, ovr_l, ovr_m;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clk), .reset(reset), .ser_input(ser_input),
    .frame(frame), .par_output(par_l), .full(full_l),
    .ack(ack), .frame_error(fe_l), .overrun(ovr_l)
  );

  deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clock(clk), .reset(reset), .ser_input(ser_input),
    .frame(frame), .par_output(par_m), .full(full_m),
    .ack(ack), .frame_error(fe_m), .overrun(ovr_m)
  );

  // reference model state
  int m_run = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_word = '0;
  logic m_full = 1'b0;
  logic m_ovr = 1'b0;
  logic m_fe = 1'b0;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is the run of consecutive frame=1 cycles;
  // the word is its first W bits, in arrival order.
  task automatic model_step(input logic r, input logic f,
                            input logic s, input logic a);
    logic done;
    done = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_run = 0;
      m_word = '0;
      m_full = 1'b0;
      m_ovr = 1'b0;
      return;
    end
    if (f) begin
      m_run++;
      if (m_run <= W) m_acc[m_run-1] = s;
      if (m_run == W) done = 1'b1;
      if (m_run == W + 1) m_fe = 1'b1;
    end else begin
      if (m_run > 0 && m_run < W) m_fe = 1'b1;
      m_run = 0;
    end
    if (done && m_full && !a) m_ovr = 1'b1;
    else if (a && m_full) m_ovr = 1'b0;
    if (done && (!m_full || a)) begin
      m_word = m_acc;
      m_full = 1'b1;
    end else if (a && m_full) begin
      m_full = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic f,
                      input logic s, input logic a);
    reset = r;
    frame = f;
    ser_input = s;
    ack = a;
    @(posedge clk);
    model_step(r, f, s, a);
    #1;
    chk("mdl_full_l", full_l, m_full);
    chk("mdl_full_m", full_m, m_full);
    chk("mdl_par_l", par_l, m_word);
    chk("mdl_par_m", par_m, rev(m_word));
    chk("mdl_fe_l", fe_l, m_fe);
    chk("mdl_fe_m", fe_m, m_fe);
    chk("mdl_ovr_l", ovr_l, m_ovr);
    chk("mdl_ovr_m", ovr_m, m_ovr);
  endtask

  task automatic send(input logic [W-1:0] w, input int n,
                      input logic ack_last);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, (i < W) ? w[i] : 1'b0,
           (i == n - 1) ? ack_last : 1'b0);
    end
  endtask

  typedef struct {
    logic r, f, s, a;
    logic xfull;
    logic [W-1:0] xpar;
    logic xfe, xovr;
  } vec_t;

  function automatic vec_t mk(input logic r, f, s, a, xfull,
                              input logic [W-1:0] xpar,
                              input logic xfe, xovr);
    vec_t v;
    v.r = r; v.f = f; v.s = s; v.a = a;
    v.xfull = xfull; v.xpar = xpar;
    v.xfe = xfe; v.xovr = xovr;
    return v;
  endfunction

  vec_t tv[$];

  initial begin
    // reset
    tv.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0));
    // 8'h4D, LSB first: 1,0,1,1,0,0,1,0
    tv.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h4D, 0, 0));
    // 8'hA5 while full, no ack: 1,0,1,0,0,1,0,1
    tv.push_back(mk(0, 1, 1, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 8'h4D, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 8'h4D, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 8'h4D, 0, 1));
    // ack clears full and overrun
    tv.push_back(mk(0, 0, 0, 1, 0, 8'h4D, 0, 0));

    foreach (tv[k]) begin
      step(tv[k].r, tv[k].f, tv[k].s, tv[k].a);
      chk("tv_full", full_l, tv[k].xfull);
      chk("tv_par_l", par_l, tv[k].xpar);
      chk("tv_par_m", par_m, rev(tv[k].xpar));
      chk("tv_fe", fe_l, tv[k].xfe);
      chk("tv_ovr", ovr_l, tv[k].xovr);
    end

    // short frame, then a good one
    send(8'h15, 5, 1'b0);
    step(0, 0, 0, 0);
    chk("short_fe", fe_l, 1);
    chk("short_full", full_l, 0);
    step(0, 0, 0, 0);
    chk("short_fe_once", fe_l, 0);
    chk("short_par", par_l, 8'h4D);
    send(8'h3C, 8, 1'b0);
    chk("w3c_full", full_l, 1);
    chk("w3c_par_l", par_l, 8'h3C);
    chk("w3c_par_m", par_m, 8'h3C);
    step(0, 0, 0, 1);
    chk("w3c_ack", full_l, 0);

    // long frame: 10 cycles
    send(8'h96, 8, 1'b0);
    chk("long_par_l", par_l, 8'h96);
    chk("long_par_m", par_m, 8'h69);
    chk("long_fe8", fe_l, 0);
    step(0, 1, 1, 0);
    chk("long_fe9", fe_l, 1);
    step(0, 1, 0, 0);
    chk("long_fe10", fe_l, 0);
    step(0, 0, 0, 0);
    chk("long_end_fe", fe_l, 0);
    chk("long_end_par", par_l, 8'h96);

    // completion with same-cycle ack while full
    send(8'hFF, 8, 1'b1);
    chk("ackc_par", par_l, 8'hFF);
    chk("ackc_full", full_l, 1);
    chk("ackc_ovr", ovr_l, 0);
    step(0, 0, 0, 0);

    // reset at bit 4 of a frame, released mid-frame
    send(8'h5A, 3, 1'b0);
    step(1, 1, 1, 0);
    chk("rst_full", full_l, 0);
    chk("rst_par_l", par_l, 0);
    chk("rst_par_m", par_m, 0);
    chk("rst_ovr", ovr_l, 0);
    chk("rst_fe", fe_l, 0);
    send(8'h0F, 4, 1'b0);
    step(0, 0, 0, 0);
    chk("rst_tail_fe", fe_l, 1);
    chk("rst_tail_full", full_l, 0);
    step(0, 0, 0, 0);

    // randomized frames against the model
    for (int n = 0; n < 300; n++) begin
      int len;
      int sel;
      logic [W-1:0] d;
      sel = $urandom_range(0, 9);
      if (sel < 7) len = W;
      else if (sel < 8) len = $urandom_range(1, W - 1);
      else len = $urandom_range(W + 1, W + 3);
      d = W'($urandom);
      for (int i = 0; i < len; i++) begin
        step($urandom_range(0, 199) == 0, 1'b1,
             (i < W) ? d[i] : 1'($urandom),
             $urandom_range(0, 3) == 0);
      end
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        step(1'b0, 1'b0, 1'($urandom), $urandom_range(0, 2) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
